// File: rtl/pool_unit.sv
// Streaming 2x2 stride-2 signed max-pool over CH_NUM-channel beats in raster order.
// Even rows fold column pairs into a half-width line buffer; odd rows finish each window.
module pool_unit #(
    parameter int CH_NUM         = 18,
    parameter int DATA_WIDTH     = 8,
    parameter int COL_ADDR_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [COL_ADDR_WIDTH:0]      cfg_width,
    input  logic [COL_ADDR_WIDTH:0]      cfg_height,
    input  logic [CH_NUM*DATA_WIDTH-1:0] pool_data_in,
    input  logic                         pool_valid_in,
    output logic [CH_NUM*DATA_WIDTH-1:0] pool_data_out,
    output logic                         pool_valid_out,
    output logic                         frame_done
);

    localparam int BW       = CH_NUM * DATA_WIDTH;
    localparam int AW       = COL_ADDR_WIDTH;
    localparam int LB_DEPTH = 2 ** (AW - 1);
    localparam logic [AW:0]   DIM_ONE = 1;
    localparam logic [AW-1:0] CNT_ONE = 1;

    logic [AW-1:0] r_col;
    logic [AW-1:0] r_row;
    logic [AW:0]   r_width;
    logic [AW:0]   r_height;
    logic [BW-1:0] r_hold;
    logic [BW-1:0] r_lb_q;
    logic [BW-1:0] r_data_out;
    logic          r_valid_out;
    logic          r_frame_done;
    logic [BW-1:0] r_linebuf [LB_DEPTH];

    logic          w_first;
    logic [AW:0]   w_width;
    logic [AW:0]   w_height;
    logic          w_last_col;
    logic          w_last_row;
    logic          w_active;
    logic          w_odd_col;
    logic          w_odd_row;
    logic [AW-2:0] w_lb_addr;
    logic [BW-1:0] w_max_hold_in;
    logic [BW-1:0] w_max_lb_hold;
    logic [BW-1:0] w_max_all;

    // On the first beat of a frame the live cfg applies, so back-to-back frames need no bubble.
    assign w_first    = (r_row == '0) && (r_col == '0);
    assign w_width    = w_first ? cfg_width  : r_width;
    assign w_height   = w_first ? cfg_height : r_height;
    assign w_last_col = ({1'b0, r_col} == (w_width  - DIM_ONE));
    assign w_last_row = ({1'b0, r_row} == (w_height - DIM_ONE));
    assign w_odd_col  = r_col[0];
    assign w_odd_row  = r_row[0];
    assign w_lb_addr  = r_col[AW-1:1];

    // A trailing odd column or odd row only advances the counters.
    assign w_active = pool_valid_in
                    && !(w_width[0]  && w_last_col)
                    && !(w_height[0] && w_last_row);

    generate
        for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_ch
            logic signed [DATA_WIDTH-1:0] w_in;
            logic signed [DATA_WIDTH-1:0] w_hold;
            logic signed [DATA_WIDTH-1:0] w_lbq;
            logic signed [DATA_WIDTH-1:0] w_lh;

            assign w_in   = pool_data_in[gi*DATA_WIDTH +: DATA_WIDTH];
            assign w_hold = r_hold[gi*DATA_WIDTH +: DATA_WIDTH];
            assign w_lbq  = r_lb_q[gi*DATA_WIDTH +: DATA_WIDTH];
            assign w_lh   = (w_lbq < w_hold) ? w_hold : w_lbq;

            assign w_max_hold_in[gi*DATA_WIDTH +: DATA_WIDTH] = (w_hold < w_in) ? w_in : w_hold;
            assign w_max_lb_hold[gi*DATA_WIDTH +: DATA_WIDTH] = w_lh;
            assign w_max_all[gi*DATA_WIDTH +: DATA_WIDTH]     = (w_lh < w_in) ? w_in : w_lh;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col        <= '0;
            r_row        <= '0;
            r_width      <= '0;
            r_height     <= '0;
            r_hold       <= '0;
            r_data_out   <= '0;
            r_valid_out  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_valid_out  <= 1'b0;
            r_frame_done <= 1'b0;
            if (pool_valid_in) begin
                if (w_first) begin
                    r_width  <= cfg_width;
                    r_height <= cfg_height;
                end
                if (w_last_col) begin
                    r_col <= '0;
                    r_row <= w_last_row ? '0 : (r_row + CNT_ONE);
                end else begin
                    r_col <= r_col + CNT_ONE;
                end
                r_frame_done <= w_last_col && w_last_row;
            end
            if (w_active) begin
                if (!w_odd_col) begin
                    r_hold <= pool_data_in;
                end
                if (w_odd_row && w_odd_col) begin
                    r_data_out  <= w_max_all;
                    r_valid_out <= 1'b1;
                end
            end
        end
    end

    // Line buffer: written on even rows, read one beat ahead of use on odd rows.
    always_ff @(posedge clk) begin
        if (!rst && w_active && !w_odd_row && w_odd_col) begin
            r_linebuf[w_lb_addr] <= w_max_hold_in;
        end
        if (!rst && w_active && w_odd_row && !w_odd_col) begin
            r_lb_q <= r_linebuf[w_lb_addr];
        end
    end

    assign pool_data_out  = r_data_out;
    assign pool_valid_out = r_valid_out;
    assign frame_done     = r_frame_done;

endmodule

// File: doc/pool_unit.md
# pool_unit

Streaming 2x2 / stride-2 max-pooling stage directly downstream of the convolution unit. It consumes the 18-channel × 8-bit result beats the conv unit emits on `MAC_data_out`/`MAC_data_valid_out`, in raster order, and emits one pooled 144-bit beat per 2x2 window. The stage uses one half-width line buffer and no backpressure, so it accepts one beat per cycle indefinitely.

## Interface
- `CH_NUM`, 18, channels per beat
- `DATA_WIDTH`, 8, signed bits per channel
- `COL_ADDR_WIDTH`, 8, width of column/row counters; max feature-map width/height = 2^COL_ADDR_WIDTH
- `clk` input 1 — single clock, all logic rising-edge
- `rst` input 1 — synchronous, active-high reset
- `cfg_width` input COL_ADDR_WIDTH+1 — input map width in pixels, 2..2^COL_ADDR_WIDTH
- `cfg_height` input COL_ADDR_WIDTH+1 — input map height in rows, 2..2^COL_ADDR_WIDTH
- `pool_data_in` input CH_NUM*DATA_WIDTH — conv result beat; channel k at bits [k*8+7:k*8]
- `pool_valid_in` input 1 — beat qualifier
- `pool_data_out` output CH_NUM*DATA_WIDTH — pooled beat, same channel packing
- `pool_valid_out` output 1 — one-cycle qualifier per pooled beat
- `frame_done` output 1 — one-cycle pulse at the end of each input frame

## Operation
- Counters `col` (0..cfg_width-1) and `row` (0..cfg_height-1) advance only on `pool_valid_in`. `col` wraps to 0 and increments `row`. At the last beat of a frame, `row` and `col` wrap to 0.
- `cfg_width`/`cfg_height` are latched on the first beat of each frame (`row==0 && col==0 && pool_valid_in`). Changes mid-frame have no effect.
- All compares are per channel and signed two's complement. max(a,b) chooses b when a<b. Ties are indistinguishable.
- The line buffer holds 2^(COL_ADDR_WIDTH-1) entries × CH_NUM*DATA_WIDTH bits, uses synchronous read, and is indexed by `col>>1`.
- Even row, even col: `hold <= in`.
- Even row, odd col: `linebuf[col>>1] <= max(hold, in)`.
- Odd row, even col: `hold <= in`; issue a linebuf read at `col>>1`. Read data is held until the next read.
- Odd row, odd col: `pool_data_out <= max(max(linebuf_q, hold), in)`; `pool_valid_out <= 1`.
- Odd `cfg_width`: the last-column beat of each row is counted and discarded (floor semantics).
- Odd `cfg_height`: the last row is counted; it produces no output and does not write linebuf.
- Output count per frame = floor(W/2)*floor(H/2).
- `frame_done` is asserted in the cycle after the final input beat of the frame. That is the same cycle as the last `pool_valid_out` when both dimensions are even.

## Timing
- Latency: `pool_valid_out` is asserted exactly 1 cycle after the accepting odd-row/odd-col input beat.
- `pool_data_out` holds its value between valids. The bench checks it only when `pool_valid_out` is high.
- Valid gaps of any length are legal between any beats. State and linebuf_q hold across gaps.
- Throughput: one input beat per cycle sustained, including back-to-back frames. A frame's first beat may arrive in the cycle after its predecessor's last beat.
- Reset values: `pool_data_out`=0, `pool_valid_out`=0, `frame_done`=0, `col`=0, `row`=0, `hold`=0.
- Line buffer contents are not reset. They are always overwritten on an even row before being read.
- Reset mid-frame: the partial frame is abandoned and no output or `frame_done` is produced for it. The first valid beat after `rst` deasserts is pixel (0,0) of a new frame.
- `rst` and `pool_valid_in` in the same cycle: the beat is dropped.

## Test plan
- 4x4 frame, every channel = r*4+c, continuous valid -> exactly 4 outputs, all channels 5, 7, 13, 15 in order, each 1 cycle after inputs (1,1),(1,3),(3,1),(3,3); `frame_done` with the 4th output.
- Signed: 2x2 frame, channel 0 = {-128,-3,-1,-128}, channel 17 = {127,-128,0,5} -> channel 0 = -1 (0xFF), channel 17 = 127 (0x7F).
- Random valid gaps (0-5 idle cycles) on an 8x6 random frame -> 12 outputs matching the reference model; no extra valids during gaps.
- Odd dims 5x3 -> 2 outputs only (windows cols 0-1 and 2-3 of rows 0-1); column 4 and row 2 are ignored; `frame_done` 1 cycle after beat 15.
- `rst` asserted after 6 beats of a 4x4 frame -> no output; a following clean 4x4 frame produces exactly the 4 values of scenario 1.
- Back-to-back frames 4x4 then 2x2 (`cfg` changed between them, no idle cycles) -> 4 then 1 outputs, two `frame_done` pulses; the second frame uses the new configuration.
